step_sequencer: RTL
===================

Name: step_sequencer

Overview:
Parametrised successor to the 8-step music controller. It reads a multi-step note bar and walks through it one step at a time, driving note enables to the flash audio player for a programmable number of player-valid cycles per step. In PLAY mode it scans a bar-enable mask, requests each enabled bar from SRAM with a request/acknowledge handshake, and plays it. Tempo is selectable from TEMPO_LEVELS power-of-two levels. It sits between the VGA note detector / SRAM bar store and the flash audio player.

Parameters:
STEPS, 8, steps per bar (≥2)
NOTE_W, 8, note-enable bits per step
BARS, 8, bar slots in SRAM (≥2)
TEMPO_LEVELS, 3, number of tempo levels (≥1)
BASE_DELAY, 2000000, step length at level 0, in valid cycles minus 1
CNT_W, 32, step counter width; must hold BASE_DELAY<<(TEMPO_LEVELS-1)

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-low
i_mode  in  1  0 = RECORD, 1 = PLAY
i_save  in  1  active-low: RECORD captures iNote; PLAY starts playback
iNote  in  STEPS*NOTE_W  current bar; step k = bits [k*NOTE_W +: NOTE_W]
iBarMask  in  BARS  1 = bar slot enabled for playback
i_read_n  in  1  one-cycle pulse: requested bar is now on iNote
iFlashValid  in  1  player advancing; gates step counter
iSpeedUp  in  1  one-cycle pulse, faster tempo
iSpeedDown  in  1  one-cycle pulse, slower tempo
o_signal  out  1  bar read request to SRAM
oBar  out  $clog2(BARS)  bar index being requested/played
o_step  out  $clog2(STEPS)  current step index
o_music_enb  out  NOTE_W  note enables to player
o_rst  out  1  player restart strobe
o_S_Note  out  STEPS*NOTE_W  captured bar for SRAM write
o_level  out  $clog2(TEMPO_LEVELS)+1  current tempo level

Behaviour:
- All outputs registered (1-cycle latency from inputs).
- Reset values: state IDLE, o_signal 0, oBar 0, o_step 0, o_music_enb 0, o_rst 1, o_S_Note 0, o_level 1 (0 if TEMPO_LEVELS==1), count 0.
- delay = BASE_DELAY << level. A step lasts delay+1 cycles with iFlashValid=1. Cycles with iFlashValid=0 hold the count.
- Tempo: iSpeedUp decrements level (saturates at 0) and sets count to count>>1. iSpeedDown increments level (saturates at TEMPO_LEVELS-1) and sets count to count<<1, clamped to the new delay. Both pulses in the same cycle, or a pulse while saturated: no change. Tempo changes are accepted in every state.
- Mode change: any change of i_mode forces IDLE the next cycle with o_rst=1, count=0, o_signal=0, o_music_enb=0, o_step=0. oBar is kept in RECORD and cleared to 0 on entry to PLAY.
- RECORD mode: o_S_Note <= iNote on every cycle with i_save=0.
  - IDLE: o_rst=1, count=0. Go to STEP (step 0) when iNote≠0.
  - STEP: if iNote==0, go to IDLE. After the last step, wrap to step 0.
- PLAY mode states:
  - IDLE: o_rst=1, count=0. Go to SEEK when i_save=0.
  - SEEK: if iBarMask[oBar]=1, assert o_signal and go to FETCH. Otherwise oBar++ (wrap BARS-1→0), one slot per cycle. An all-zero mask keeps the block in SEEK indefinitely.
  - FETCH: hold o_signal=1 until i_read_n=1. Then o_signal=0, o_step=0, go to STEP.
  - STEP: o_rst=0, o_music_enb = slice(o_step). When iFlashValid and count==delay: count=0, o_rst=1 for one cycle, o_step++. After the last step: oBar++ (wrap) and go to SEEK.
- o_music_enb reads iNote live every cycle in STEP, so zero-valued slices produce rests.

Optional Feature:
SEQ_ONESHOT_EN
- Defined: adds input port i_oneshot (1 bit). In PLAY, if i_oneshot=1 when oBar wraps BARS-1→0 at the end of a bar, go to IDLE instead of SEEK. oBar is 0 on entry to IDLE.
- Undefined: the port is absent and playback loops forever.

Decomposition:
- Package seq_pkg: state enum {IDLE, SEEK, FETCH, STEP}, mode enum {RECORD, PLAY}, function step_delay(base, level).
- Sub-module seq_tempo_timer: owns the level register, the count register and the saturation/rescale logic. Outputs step_done and level.

Test Plan:
- Bench parameters BASE_DELAY=3, TEMPO_LEVELS=3, STEPS=8, NOTE_W=8, BARS=8.
- Reset, RECORD, iNote=64'h0807060504030201, iFlashValid=1 → o_music_enb steps 01..08, each held 7 cycles (level 1). o_rst pulses at each boundary. Step wraps 7→0.
- RECORD, set iNote=0 during step 3 → IDLE next cycle, o_rst=1, o_music_enb=0. Pulse i_save=0 → o_S_Note equals iNote.
- PLAY, iBarMask=8'b0010_0100, pulse i_save=0 → SEEK walks to bar 2, o_signal=1 held 5 cycles until i_read_n pulse. Plays 8 steps, then oBar=5, then wraps and returns to 2.
- Toggle iFlashValid 50% in STEP → step length doubles in wall-clock cycles. Count frozen while iFlashValid=0.
- At count=5, level 1, pulse iSpeedUp → level 0, count 2, step ends after 2 more valid cycles. Pulse iSpeedUp again → level stays 0. Pulse iSpeedUp and iSpeedDown together → no change.
- Drop i_mode to 0 mid-FETCH → o_signal 0 next cycle, IDLE. With SEQ_ONESHOT_EN and i_oneshot=1, mask 8'h80 → one bar played, then IDLE with oBar=0.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and tempo helper for the step sequencer
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    FETCH = 2'd2,
    STEP  = 2'd3
  } seq_state_t;

  typedef enum logic {
    RECORD = 1'b0,
    PLAY   = 1'b1
  } seq_mode_t;

  // Step length (in valid cycles minus one) at a given tempo level.
  function automatic longint unsigned step_delay(longint unsigned base, int unsigned level);
    return base << level;
  endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// rtl/step_sequencer_if.sv - bar-store handshake between the sequencer and SRAM
interface step_sequencer_if #(
  parameter int STEPS  = 8,
  parameter int NOTE_W = 8,
  parameter int BARS   = 8
);
  logic                        o_signal;
  logic [$clog2(BARS)-1:0]     oBar;
  logic                        i_read_n;
  logic [STEPS*NOTE_W-1:0]     iNote;
  logic [BARS-1:0]             iBarMask;
  logic [STEPS*NOTE_W-1:0]     o_S_Note;

  modport master (
    output o_signal, oBar, o_S_Note,
    input  i_read_n, iNote, iBarMask
  );

  modport slave (
    input  o_signal, oBar, o_S_Note,
    output i_read_n, iNote, iBarMask
  );
endinterface

// File: rtl/seq_tempo_timer.sv
// rtl/seq_tempo_timer.sv - tempo level register and per-step valid-cycle counter
module seq_tempo_timer
  import seq_pkg::*;
#(
  parameter int TEMPO_LEVELS = 3,
  parameter int BASE_DELAY   = 2000000,
  parameter int CNT_W        = 32,
  parameter int LVL_W        = $clog2(TEMPO_LEVELS) + 1
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             clear,
  input  logic             run,
  input  logic             valid,
  input  logic             speed_up,
  input  logic             speed_down,
  output logic             step_done,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(TEMPO_LEVELS - 1);
  localparam logic [LVL_W-1:0] LVL_RST = (TEMPO_LEVELS > 1) ? LVL_W'(1) : '0;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] delay_up;
  logic [CNT_W-1:0] count_x2;
  logic [CNT_W:0]   count_dbl;
  logic             up_ok;
  logic             dn_ok;

  assign delay    = CNT_W'(step_delay(64'(BASE_DELAY), 32'(level)));
  assign delay_up = CNT_W'(step_delay(64'(BASE_DELAY), 32'(level) + 32'd1));

  // Simultaneous up/down cancel; a pulse at the saturated end is ignored.
  assign up_ok = speed_up && !speed_down && (level != '0);
  assign dn_ok = speed_down && !speed_up && (level != LVL_MAX);

  assign count_dbl = {count, 1'b0};
  assign count_x2  = (count_dbl > {1'b0, delay_up}) ? delay_up : count_dbl[CNT_W-1:0];

  assign step_done = run && valid && (count == delay);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      level <= LVL_RST;
      count <= '0;
    end else begin
      if (up_ok)
        level <= level - LVL_W'(1);
      else if (dn_ok)
        level <= level + LVL_W'(1);

      // Rescaling keeps the elapsed fraction of the step across a tempo change.
      if (clear)
        count <= '0;
      else if (step_done)
        count <= '0;
      else if (up_ok)
        count <= count >> 1;
      else if (dn_ok)
        count <= count_x2;
      else if (run && valid)
        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - bar recorder/player stepping note enables to the flash player
// Optional SEQ_ONESHOT_EN adds i_oneshot: stop in IDLE after the last bar slot instead of looping.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int STEPS        = 8,
  parameter int NOTE_W       = 8,
  parameter int BARS         = 8,
  parameter int TEMPO_LEVELS = 3,
  parameter int BASE_DELAY   = 2000000,
  parameter int CNT_W        = 32
) (
  input  logic                              iCLK,
  input  logic                              iRST,
  input  logic                              i_mode,
  input  logic                              i_save,
`ifdef SEQ_ONESHOT_EN
  input  logic                              i_oneshot,
`endif
  input  logic                              iFlashValid,
  input  logic                              iSpeedUp,
  input  logic                              iSpeedDown,
  step_sequencer_if.master                  sram,
  output logic [$clog2(STEPS)-1:0]          o_step,
  output logic [NOTE_W-1:0]                 o_music_enb,
  output logic                              o_rst,
  output logic [$clog2(TEMPO_LEVELS):0]     o_level
);

  localparam int STEP_W = $clog2(STEPS);
  localparam int BAR_W  = $clog2(BARS);
  localparam int LVL_W  = $clog2(TEMPO_LEVELS) + 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [BAR_W-1:0]  BAR_LAST  = BAR_W'(BARS - 1);

  seq_state_t              state, state_d;
  seq_mode_t               mode;
  logic                    mode_q;
  logic                    mode_chg;
  logic                    signal_q, signal_d;
  logic [BAR_W-1:0]        bar_q, bar_d, bar_inc;
  logic [STEP_W-1:0]       step_d;
  logic                    last_step;
  logic [NOTE_W-1:0]       enb_d;
  logic                    rst_d;
  logic [STEPS*NOTE_W-1:0] snote_q, snote_d;
  logic                    tmr_clear;
  logic                    tmr_run;
  logic                    step_done;
  logic [LVL_W-1:0]        level;

  assign mode      = seq_mode_t'(i_mode);
  assign mode_chg  = (i_mode != mode_q);
  assign bar_inc   = (bar_q == BAR_LAST) ? '0 : bar_q + BAR_W'(1);
  assign last_step = (o_step == STEP_LAST);

  seq_tempo_timer #(
    .TEMPO_LEVELS (TEMPO_LEVELS),
    .BASE_DELAY   (BASE_DELAY),
    .CNT_W        (CNT_W),
    .LVL_W        (LVL_W)
  ) u_tempo (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .clear      (tmr_clear),
    .run        (tmr_run),
    .valid      (iFlashValid),
    .speed_up   (iSpeedUp),
    .speed_down (iSpeedDown),
    .step_done  (step_done),
    .level      (level)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= IDLE;
      mode_q      <= 1'b0;
      signal_q    <= 1'b0;
      bar_q       <= '0;
      o_step      <= '0;
      o_music_enb <= '0;
      o_rst       <= 1'b1;
      snote_q     <= '0;
    end else begin
      state       <= state_d;
      mode_q      <= i_mode;
      signal_q    <= signal_d;
      bar_q       <= bar_d;
      o_step      <= step_d;
      o_music_enb <= enb_d;
      o_rst       <= rst_d;
      snote_q     <= snote_d;
    end
  end

  always_comb begin
    state_d = state;
    bar_d   = bar_q;
    step_d  = o_step;
    if (mode_chg) begin
      state_d = IDLE;
      step_d  = '0;
      if (mode == PLAY)
        bar_d = '0;
    end else begin
      case (state)
        IDLE: begin
          step_d = '0;
          if (mode == RECORD) begin
            if (sram.iNote != '0)
              state_d = STEP;
          end else if (!i_save) begin
            state_d = SEEK;
          end
        end
        SEEK: begin
          if (mode == RECORD)
            state_d = IDLE;
          else if (sram.iBarMask[bar_q])
            state_d = FETCH;
          else
            bar_d = bar_inc;
        end
        FETCH: begin
          if (mode == RECORD) begin
            state_d = IDLE;
          end else if (sram.i_read_n) begin
            state_d = STEP;
            step_d  = '0;
          end
        end
        STEP: begin
          if (mode == RECORD) begin
            if (sram.iNote == '0) begin
              state_d = IDLE;
              step_d  = '0;
            end else if (step_done) begin
              step_d = last_step ? '0 : o_step + STEP_W'(1);
            end
          end else if (step_done) begin
            if (last_step) begin
              step_d  = '0;
              bar_d   = bar_inc;
              state_d = SEEK;
`ifdef SEQ_ONESHOT_EN
              if (i_oneshot && (bar_q == BAR_LAST))
                state_d = IDLE;
`endif
            end else begin
              step_d = o_step + STEP_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so enables line up with o_step.
  always_comb begin
    signal_d  = (state_d == FETCH);
    rst_d     = (state_d != STEP) || step_done;
    enb_d     = '0;
    if (state_d == STEP)
      enb_d = sram.iNote[step_d*NOTE_W +: NOTE_W];
    snote_d   = snote_q;
    if ((mode == RECORD) && !i_save)
      snote_d = sram.iNote;
    tmr_clear = (state_d != STEP);
    tmr_run   = (state == STEP);
  end

  assign sram.o_signal = signal_q;
  assign sram.oBar     = bar_q;
  assign sram.o_S_Note = snote_q;
  assign o_level       = level;

endmodule
